// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        WAIT    = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam int          PC_INC        = 4;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus, single outstanding request.
interface fetch_stage_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata
    );
endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush beats hold beats load; otherwise a bubble.
module ifid_reg #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              enable,
    input  logic              load,
    input  logic [31:0]       load_instr,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic [ADDR_W-1:0] load_pc4,
    output logic              ifid_valid,
    output logic [31:0]       ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [ADDR_W-1:0] ifid_pc4
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
            ifid_pc    <= '0;
            ifid_pc4   <= '0;
        end else if (flush) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
        end else if (!enable) begin
            ifid_valid <= ifid_valid;
        end else if (load) begin
            ifid_valid <= 1'b1;
            ifid_instr <= load_instr;
            ifid_pc    <= load_pc;
            ifid_pc4   <= load_pc4;
        end else begin
            // pc fields are kept so a bubble still carries the last link value
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, single-outstanding imem FSM, one-entry skid and the IF/ID register.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEF),
    parameter logic [31:0]       NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_1,
    input  logic              reset1,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    fetch_stage_if.master     imem,
    output logic              ifid_valid,
    output logic [31:0]       ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [ADDR_W-1:0] ifid_pc4
);

    fetch_state_e      state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, pc_plus4;
    logic [31:0]       skid, skid_n;
    logic              hs;
    logic              ld_vld;
    logic [31:0]       ld_instr;

    assign pc_plus4       = pc + ADDR_W'(PC_INC);
    assign hs             = (state == REQ) && imem.imem_ready && rst_n;
    assign imem.imem_req  = rst_n && (state == REQ);
    assign imem.imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= REQ;
            pc    <= RESET_PC;
            skid  <= NOP_INSTR;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            skid  <= skid_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        skid_n   = skid;
        ld_vld   = 1'b0;
        ld_instr = imem.imem_rdata;
        case (state)
            REQ: if (hs) state_n = WAIT;
            WAIT: begin
                if (imem.imem_rvalid) begin
                    if (!enable_1) begin
                        skid_n  = imem.imem_rdata;
                        state_n = HOLD;
                    end else begin
                        // a simultaneous flush drops the word; same pc is refetched
                        state_n = REQ;
                        if (!reset1) begin
                            ld_vld = 1'b1;
                            pc_n   = pc_plus4;
                        end
                    end
                end
            end
            HOLD: begin
                if (enable_1) begin
                    ld_instr = skid;
                    state_n  = REQ;
                    if (!reset1) begin
                        ld_vld = 1'b1;
                        pc_n   = pc_plus4;
                    end
                end
            end
            DISCARD: if (imem.imem_rvalid) state_n = REQ;
            default: state_n = REQ;
        endcase

        if (redirect_valid) begin
            pc_n   = redirect_pc;
            skid_n = NOP_INSTR;
            ld_vld = 1'b0;
            // any request still in flight must have its response swallowed
            if (hs || (((state == WAIT) || (state == DISCARD)) && !imem.imem_rvalid))
                state_n = DISCARD;
            else
                state_n = REQ;
        end
    end

    ifid_reg #(
        .ADDR_W    (ADDR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (reset1),
        .enable     (enable_1),
        .load       (ld_vld),
        .load_instr (ld_instr),
        .load_pc    (pc),
        .load_pc4   (pc_plus4),
        .ifid_valid (ifid_valid),
        .ifid_instr (ifid_instr),
        .ifid_pc    (ifid_pc),
        .ifid_pc4   (ifid_pc4)
    );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage pipelined CPU.
- Sits directly upstream of the decode stage and hazard logic.
- Owns the PC and a single-outstanding instruction-memory request handshake.
- Consumes the hazard unit's enable_1 (IF/ID hold) and reset1 (IF/ID flush) outputs; consumes redirect requests from branch/jump resolution.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INSTR, 32'h0000_0000, instruction word driven into IF/ID on bubble/flush
ADDR_W, 32, PC/address width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable_1  in  1  1 = IF/ID may advance; 0 = stall (hold IF/ID and PC)
reset1  in  1  flush IF/ID to bubble this cycle
redirect_valid  in  1  branch/jump taken; load PC from redirect_pc
redirect_pc  in  ADDR_W  redirect target
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_W  fetch address (= pc)
imem_ready  in  1  memory accepts request when imem_req && imem_ready
imem_rvalid  in  1  response valid (exactly one per accepted request, >=1 cycle later)
imem_rdata  in  32  instruction word
ifid_valid  out  1  IF/ID holds a real instruction
ifid_instr  out  32  IF/ID instruction
ifid_pc  out  ADDR_W  PC of ifid_instr
ifid_pc4  out  ADDR_W  ifid_pc + 4 (link value)

Behaviour:
- Reset (rst_n=0, async): pc=RESET_PC, state=REQ, skid empty, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc4=0. imem_req=0 while rst_n=0.
- State machine, one request outstanding max:
  - REQ: imem_req=1, imem_addr=pc. On handshake -> WAIT; otherwise stay.
  - WAIT: imem_req=0. On imem_rvalid:
    - enable_1=1 and reset1=0: load IF/ID {1, rdata, pc, pc+4}; pc<=pc+4; -> REQ.
    - enable_1=0: capture rdata into skid buffer -> HOLD.
  - HOLD: imem_req=0. When enable_1=1: load IF/ID from skid; pc<=pc+4; -> REQ.
  - DISCARD: imem_req=0. Drop the next imem_rvalid, then -> REQ.
- Fetch is non-speculative past a stall: at most one instruction (the skid) is waiting.
- IF/ID update priority, per cycle:
  1. reset1=1: valid=0, instr=NOP_INSTR; wins even if enable_1=0.
  2. enable_1=0: hold all IF/ID fields.
  3. New instruction available: load it.
  4. Otherwise: bubble (valid=0, instr=NOP_INSTR; pc fields unchanged).
- Redirect (redirect_valid=1), highest priority for the PC:
  - pc<=redirect_pc; skid cleared; next state REQ.
  - If a request is outstanding (WAIT), or is accepted in this same cycle (REQ with imem_ready=1): next state DISCARD. The request accepted in that cycle still uses the old pc.
  - Redirect and imem_rvalid in the same WAIT cycle: data dropped, next state REQ.
  - Redirect does not itself flush IF/ID; upstream asserts reset1 for that.
  - Redirect is honoured even when enable_1=0.
- If reset1 and a response arrive in the same WAIT cycle with enable_1=1: the IF/ID flush wins, the response is dropped, pc is NOT advanced, and state -> REQ (the instruction is refetched unless a redirect replaces it).
- Arithmetic: pc+4 is modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0. Bits [1:0] of redirect_pc are passed through unchanged (no alignment check).
- Reset asserted mid-transaction: all state cleared immediately. A late imem_rvalid after reset release, with no outstanding request, is ignored.
- Latency: best case one instruction every 2 cycles with a 1-cycle memory (REQ->WAIT->REQ). Outputs change only on clk edges or async reset.

Decomposition:
- Package fetch_pkg: state enum {REQ, WAIT, HOLD, DISCARD} (2 bits), NOP_INSTR and RESET_PC default constants, PC_INC=4.
- Sub-module ifid_reg: IF/ID register with flush/hold/load/bubble priority. Fetch_stage contains the FSM, PC, skid buffer and the ifid_reg instance.

Test Plan:
- Reset then 1-cycle memory returning 0x2001_0005 at 0x0: imem_addr 0x0, then 0x4; ifid={1,0x20010005,0x0,0x4} two cycles after reset release.
- Stall: response arrives while enable_1=0 for 3 cycles -> IF/ID held, no new imem_req; enable_1=1 loads the skid word and pc advances by 4.
- Redirect to 0x0000_0100 while WAIT -> the response that arrives is dropped (DISCARD), next imem_addr=0x100, ifid_pc never shows the stale PC.
- reset1 with enable_1=0 -> ifid_valid=0, instr=NOP next edge. reset1 alone with a response arriving -> response dropped, same PC refetched.
- pc=0xFFFF_FFFC fetch completes -> next imem_addr=0x0000_0000, ifid_pc4=0x0.
- rst_n pulsed low while WAIT -> outputs reset asynchronously; a stale imem_rvalid after release does not load IF/ID; first request is to RESET_PC.
